// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-buffer path: RAM geometry and RGB332 pixel field layout.
package vga_pkg;

    localparam int VGA_ADDR_W = 15;
    localparam int VGA_DATA_W = 16;
    localparam int VGA_DEPTH  = 32768;

    // Bit positions of the colour fields inside one 8-bit RGB332 pixel.
    localparam int R_LSB = 0;
    localparam int G_LSB = 3;
    localparam int B_LSB = 6;

    // Index width needed to address a bank of the given depth (at least one bit).
    function automatic int bank_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vga_ram_bank.sv
// Plain simple-dual-port memory with a registered read; kept free of reset so it maps onto block RAM.
module vga_ram_bank #(
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int DEPTH = 32768
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // Read and write share the edge; the non-blocking write makes a same-address read see the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_ram.sv
// Frame-buffer RAM: CPU write port, video read port, one-cycle registered read with reset and range guarding.
module vga_ram
    import vga_pkg::*;
#(
    parameter int ADDR_W = VGA_ADDR_W,
    parameter int DATA_W = VGA_DATA_W,
    parameter int DEPTH  = VGA_DEPTH
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              rst_n
);

    localparam int              BANK_AW = bank_addr_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic               rd_in_range;
    logic               wr_in_range;
    logic               bank_we;
    logic [BANK_AW-1:0] bank_rd_addr;
    logic [BANK_AW-1:0] bank_wr_addr;
    logic [DATA_W-1:0]  bank_q;
    logic               rd_ok_d;
    logic               rd_ok_q;

    always_comb begin
        rd_in_range  = ({1'b0, rdaddress} < DEPTH_X);
        wr_in_range  = ({1'b0, wraddress} < DEPTH_X);
        bank_rd_addr = rd_in_range ? rdaddress[BANK_AW-1:0] : '0;
        bank_wr_addr = wraddress[BANK_AW-1:0];
        // rst_n gates the write so an edge seen while reset is held never commits.
        bank_we      = wren & rst_n & wr_in_range;
        rd_ok_d      = rd_in_range;
    end

    vga_ram_bank #(
        .AW    (BANK_AW),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .we      (bank_we),
        .wr_addr (bank_wr_addr),
        .wr_data (data),
        .rd_addr (bank_rd_addr),
        .rd_data (bank_q)
    );

    // Clearing this flag asynchronously forces q to zero the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_ok_d;
        end
    end

    assign q = rd_ok_q ? bank_q : '0;

endmodule

// File: tb/tb_vga_ram.sv
// Randomised self-checking bench for vga_ram, built with DEPTH=4096 so out-of-range addresses are reachable.
module tb_vga_ram;

    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic [AW-1:0] rdaddress;
    logic [AW-1:0] wraddress;
    logic          wren;
    logic [DW-1:0] q;

    int n_cmp;
    int n_bad;

    // Reference memory: only addresses the bench has written hold known contents.
    logic [DW-1:0] model [int];

    vga_ram #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q),
        .rst_n     (rst_n)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: q=%h required=bench completion", q);
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected word for a read issued before the edge, i.e. content before that edge's write.
    function automatic bit predict(input int ra, output logic [DW-1:0] exp);
        if (ra >= DEPTH) begin
            exp = '0;
            return 1'b1;
        end
        if (model.exists(ra)) begin
            exp = model[ra];
            return 1'b1;
        end
        exp = '0;
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic we, input int wa, input logic [DW-1:0] wd,
                               input int ra, input string tag);
        logic [DW-1:0] exp;
        bit            known;
        @(negedge clk);
        wren      = we;
        wraddress = AW'(wa);
        data      = wd;
        rdaddress = AW'(ra);
        known = predict(ra, exp);
        if (we && wa < DEPTH) model[wa] = wd;
        @(posedge clk);
        #1;
        if (known) check(tag, q, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] exp;
        int            addr;
        int            sup_addr;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        wren      = 1'b0;
        data      = '0;
        rdaddress = '0;
        wraddress = '0;

        // Reset held for three cycles, with a write attempted that must not land.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wren = 1'b1; wraddress = AW'(5); data = 16'hDEAD;
            #1 check("reset_q", q, '0);
            @(posedge clk);
            #1 check("reset_q_edge", q, '0);
        end
        @(negedge clk);
        wren  = 1'b0;
        rst_n = 1'b1;
        drive_cycle(1'b0, 0, '0, 0, "first_read");

        // Write then read one cycle later.
        drive_cycle(1'b1, 16'h0010, 16'hA5C3, 0, "wr_a5c3");
        drive_cycle(1'b0, 0, '0, 16'h0010, "rd_a5c3");
        check("rd_a5c3_const", q, 16'hA5C3);

        // Read-during-write returns the old word, then the new one.
        drive_cycle(1'b1, 16'h0100, 16'h1111, 0, "preload");
        drive_cycle(1'b1, 16'h0100, 16'h2222, 16'h0100, "rdw_old");
        check("rdw_old_const", q, 16'h1111);
        drive_cycle(1'b0, 0, '0, 16'h0100, "rdw_new");
        check("rdw_new_const", q, 16'h2222);

        // Streaming fill then back-to-back readback.
        for (int a = 0; a < 4016; a++) drive_cycle(1'b1, a, DW'(a) ^ 16'h5A5A, 0, "stream_wr");
        for (int a = 0; a < 4016; a++) drive_cycle(1'b0, 0, '0, a, "stream_rd");
        check("stream_last_const", q, 16'd4015 ^ 16'h5A5A);

        // Bounds: no alias of 4096 onto 0, out-of-range read returns zero.
        drive_cycle(1'b1, 0, 16'h1234, 0, "bnd_pre");
        drive_cycle(1'b1, DEPTH, 16'hFFFF, 0, "bnd_wr");
        drive_cycle(1'b0, 0, '0, 0, "bnd_noalias");
        check("bnd_noalias_const", q, 16'h1234);
        drive_cycle(1'b0, 0, '0, DEPTH, "bnd_rd_oor");
        drive_cycle(1'b0, 0, '0, 32767, "bnd_rd_top");

        // Randomised mix over in- and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH + 100),
                        DW'($urandom), $urandom_range(0, DEPTH + 100), "rand");
        end

        // Async reset in the middle of a write burst.
        for (int a = 200; a < 208; a++) drive_cycle(1'b1, a, DW'($urandom), 0, "burst");
        sup_addr = 203;
        @(negedge clk);
        wren = 1'b1; wraddress = AW'(sup_addr); data = ~model[sup_addr];
        rdaddress = AW'(sup_addr);
        #2 rst_n = 1'b0;
        #1 check("async_q_zero", q, '0);
        @(posedge clk);
        #1 check("rst_edge_q_zero", q, '0);
        @(negedge clk);
        wren  = 1'b0;
        rst_n = 1'b1;
        for (int a = 200; a < 208; a++) drive_cycle(1'b0, 0, '0, a, "post_rst");
        addr = sup_addr;
        if (predict(addr, exp)) begin
            drive_cycle(1'b0, 0, '0, addr, "suppressed");
            check("suppressed_old", q, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
